// File: rtl/i2c_seq_pkg.sv
`timescale 1ns/1ps
// i2c_seq_pkg: command encoding (identical to the mon_i2c event stream) and sequencer states.
package i2c_seq_pkg;
  localparam logic [1:0] CMD_0 = 2'b00;
  localparam logic [1:0] CMD_1 = 2'b01;
  localparam logic [1:0] CMD_P = 2'b10;
  localparam logic [1:0] CMD_S = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_BUS_WAIT = 4'd1,
    S_ST_HD    = 4'd2,
    S_ST_LOW   = 4'd3,
    S_RS_SU    = 4'd4,
    S_RS_REL   = 4'd5,
    S_RS_HI    = 4'd6,
    S_BIT_SU   = 4'd7,
    S_BIT_REL  = 4'd8,
    S_BIT_HI   = 4'd9,
    S_HOLD     = 4'd10,
    S_P_SU     = 4'd11,
    S_P_REL    = 4'd12,
    S_P_HI     = 4'd13,
    S_P_BUF    = 4'd14
  } state_e;
endpackage

// File: rtl/i2c_sync2.sv
`timescale 1ns/1ps
// i2c_sync2: 2-FF synchronizer for an idle-high bus line; resets to 1.
module i2c_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);
  logic [1:0] r_ff;

  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) r_ff <= 2'b11;
    else       r_ff <= {r_ff[0], i_d};

  assign o_q = r_ff[1];
endmodule

// File: rtl/i2c_seq_master.sv
`timescale 1ns/1ps
// i2c_seq_master: bit-level I2C master sequencer executing S/P/0/1 commands on open-drain SCL/SDA.
// Define I2C_SEQ_STRETCH_TIMEOUT_EN to abort when SCL is held low for STRETCH_TO_CYC cycles.
module i2c_seq_master
  import i2c_seq_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int STRETCH_TO_CYC = 100000
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CNT_W-1:0] i_t_low,
  input  logic [CNT_W-1:0] i_t_su,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_scl,
  input  logic             i_sda,
  output logic             o_scl_oe,
  output logic             o_sda_oe,
  output logic             o_rd_valid,
  output logic             o_rd_bit,
  output logic             o_busy,
  output logic             o_arb_lost,
  output logic             o_cmd_err,
  output logic             o_stretch_to
);
  // One extra bit so t_low+t_su never wraps.
  localparam int CW = CNT_W + 1;

  state_e           r_state, w_nxt;
  logic [CW-1:0]    r_cnt, w_load;
  logic [CNT_W-1:0] w_tl, w_ts;
  logic             r_dat, r_busy;
  logic             r_rd_valid, r_rd_bit, r_arb, r_err, r_to;
  logic             w_scl, w_sda, w_acc, w_done, w_arb, w_to;

  i2c_sync2 u_sync_scl (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_scl), .o_q(w_scl));
  i2c_sync2 u_sync_sda (.i_clk(i_clk), .i_rst(i_rst), .i_d(i_sda), .o_q(w_sda));

  assign w_tl   = (i_t_low == '0) ? CNT_W'(1) : i_t_low;
  assign w_ts   = (i_t_su  == '0) ? CNT_W'(1) : i_t_su;
  assign w_acc  = i_cmd_valid && o_cmd_ready;
  assign w_done = (r_cnt == '0);
  assign w_arb  = ((r_state == S_BIT_HI) || (r_state == S_P_HI)) && !w_sda && !o_sda_oe;

`ifdef I2C_SEQ_STRETCH_TIMEOUT_EN
  localparam int TW = $clog2(STRETCH_TO_CYC + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_rel;
  assign w_rel = (r_state == S_BIT_REL) || (r_state == S_RS_REL) || (r_state == S_P_REL);
  assign w_to  = w_rel && !w_scl && (r_to_cnt == TW'(STRETCH_TO_CYC - 1));
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst)               r_to_cnt <= '0;
    else if (w_rel && !w_to) r_to_cnt <= r_to_cnt + TW'(1);
    else                     r_to_cnt <= '0;
`else
  assign w_to = 1'b0;
`endif

  // Phase length for the state being entered, minus one.
  always_comb begin
    w_load = '0;
    case (w_nxt)
      S_BUS_WAIT, S_ST_HD, S_ST_LOW, S_RS_HI,
      S_BIT_HI, S_P_HI, S_P_BUF: w_load = CW'(w_tl) - CW'(1);
      S_RS_SU:                   w_load = CW'(w_ts) - CW'(1);
      S_BIT_SU, S_P_SU:          w_load = CW'(w_tl) + CW'(w_ts) - CW'(1);
      default:                   w_load = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dat   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      // Bus-free wait restarts whenever either line is seen low.
      if ((w_nxt != r_state) || ((r_state == S_BUS_WAIT) && !(w_scl && w_sda)))
        r_cnt <= w_load;
      else if (!w_done)
        r_cnt <= r_cnt - CW'(1);
      if (w_nxt == S_ST_HD)                               r_dat <= 1'b1;
      else if ((r_state == S_HOLD) && w_acc && !i_cmd[1]) r_dat <= ~i_cmd[0];
      if ((r_state == S_ST_LOW) && (w_nxt == S_HOLD)) r_busy <= 1'b1;
      else if (w_nxt == S_IDLE)                       r_busy <= 1'b0;
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:     if (w_acc && (i_cmd == CMD_S)) w_nxt = S_BUS_WAIT;
      S_BUS_WAIT: if (w_scl && w_sda && w_done) w_nxt = S_ST_HD;
      S_ST_HD:    if (w_done) w_nxt = S_ST_LOW;
      S_ST_LOW:   if (w_done) w_nxt = S_HOLD;
      S_HOLD:
        if (w_acc) begin
          if (i_cmd == CMD_S)      w_nxt = S_RS_SU;
          else if (i_cmd == CMD_P) w_nxt = S_P_SU;
          else                     w_nxt = S_BIT_SU;
        end
      S_RS_SU:    if (w_done) w_nxt = S_RS_REL;
      S_RS_REL:   if (w_scl) w_nxt = S_RS_HI; else if (w_to) w_nxt = S_IDLE;
      S_RS_HI:    if (w_done) w_nxt = S_ST_HD;
      S_BIT_SU:   if (w_done) w_nxt = S_BIT_REL;
      S_BIT_REL:  if (w_scl) w_nxt = S_BIT_HI; else if (w_to) w_nxt = S_IDLE;
      S_BIT_HI:   if (w_arb) w_nxt = S_IDLE; else if (w_done) w_nxt = S_HOLD;
      S_P_SU:     if (w_done) w_nxt = S_P_REL;
      S_P_REL:    if (w_scl) w_nxt = S_P_HI; else if (w_to) w_nxt = S_IDLE;
      S_P_HI:     if (w_arb) w_nxt = S_IDLE; else if (w_done) w_nxt = S_P_BUF;
      S_P_BUF:    if (w_done) w_nxt = S_IDLE;
      default:    w_nxt = S_IDLE;
    endcase
  end

  // Line drive is a pure decode of state so reset releases the bus at once.
  always_comb begin
    o_cmd_ready = 1'b0;
    o_scl_oe    = 1'b0;
    o_sda_oe    = 1'b0;
    case (r_state)
      S_IDLE:              o_cmd_ready = !i_rst;
      S_ST_HD:             o_sda_oe    = 1'b1;
      S_ST_LOW:  begin o_scl_oe = 1'b1; o_sda_oe = 1'b1;  end
      S_HOLD:    begin o_scl_oe = 1'b1; o_sda_oe = r_dat; o_cmd_ready = 1'b1; end
      S_RS_SU:             o_scl_oe    = 1'b1;
      S_BIT_SU:  begin o_scl_oe = 1'b1; o_sda_oe = r_dat; end
      S_BIT_REL, S_BIT_HI: o_sda_oe    = r_dat;
      S_P_SU:    begin o_scl_oe = 1'b1; o_sda_oe = 1'b1;  end
      S_P_REL, S_P_HI:     o_sda_oe    = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_bit   <= 1'b0;
      r_arb      <= 1'b0;
      r_err      <= 1'b0;
      r_to       <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == S_BIT_HI) && w_done && !w_arb;
      if ((r_state == S_BIT_HI) && w_done && !w_arb) r_rd_bit <= w_sda;
      r_arb      <= w_arb;
      r_err      <= (r_state == S_IDLE) && w_acc && (i_cmd != CMD_S);
      r_to       <= w_to;
    end
  end

  assign o_rd_valid   = r_rd_valid;
  assign o_rd_bit     = r_rd_bit;
  assign o_busy       = r_busy;
  assign o_arb_lost   = r_arb;
  assign o_cmd_err    = r_err;
  assign o_stretch_to = r_to;
endmodule
